mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port word-addressed RAM between four requesters.
//  Requesters: three mm2s readers (rd0..rd2) and one s2mm writer (wr).
//  Round-robin arbitration with a bounded burst-hold, plus in-order read-data return routing.
//  Sits between the top_ram DMA engines and the backing memory model/BRAM, replacing the
//  separate per-engine memory ports.
// PARAMETERS
//  AXI_WIDTH       128   data word width in bits; must be a multiple of 8
//  AXI_ADDR_WIDTH  32    byte address width; word address width AW = AXI_ADDR_WIDTH-LSB
//  LSB             $clog2(AXI_WIDTH)-3   derived, not overridden; byte addr = word addr << LSB
//  MEM_LAT         1     RAM read latency in cycles, >=1
//  MAX_HOLD        4     max consecutive grants to one requester while others wait, >=1
// PORTS
//  clk        in   1            clock, all logic on posedge
//  rstn       in   1            asynchronous active-low reset
//  rd_req     in   3            read request per reader; addr held stable until granted
//  rd_addr    in   3*AW         reader word addresses, reader i at [i*AW +: AW]
//  rd_gnt     out  3            read grant, combinational; transfer when req&gnt
//  rd_rvalid  out  3            one-hot read-data valid, MEM_LAT cycles after grant
//  rd_rdata   out  AXI_WIDTH    shared read data, qualified by rd_rvalid
//  wr_req     in   1            write request; addr/data/strb held stable until granted
//  wr_addr    in   AW           write word address
//  wr_data    in   AXI_WIDTH    write data
//  wr_strb    in   AXI_WIDTH/8  byte enables
//  wr_gnt     out  1            write grant, combinational
//  mem_en     out  1            RAM access this cycle
//  mem_we     out  1            1 = write, 0 = read
//  mem_addr   out  AW           RAM word address
//  mem_wdata  out  AXI_WIDTH    RAM write data
//  mem_strb   out  AXI_WIDTH/8  RAM byte enables; 0 on reads
//  mem_rdata  in   AXI_WIDTH    RAM read data, valid MEM_LAT cycles after read issue
// BEHAVIOUR
//  Requester indices: 0..2 = rd0..rd2, 3 = wr. At most one grant per cycle.
//  - Grants and mem_* are combinational from req plus registered state.
//    mem_en = |grants. mem_* are muxed from the granted requester; they are 0 when nothing is granted.
//  - Registered state: fsm {IDLE, HOLD}, cur[1:0] (owner), hcnt (0..MAX_HOLD), last[1:0].
//  - IDLE: when any req is high, grant the first requester in the order last+1, last+2, ... (mod 4).
//    Next state is HOLD, with cur=k, last=k, hcnt=1.
//  - HOLD, req[cur] high and hcnt<MAX_HOLD: grant cur again and increment hcnt.
//  - HOLD, otherwise: search in the order cur+1 .. cur (mod 4), with cur considered last.
//    Grant k, then set cur=k, last=k, hcnt=1.
//    If cur is the only requester after its hold is exhausted, it is re-granted with no bubble cycle.
//  - HOLD, no req: go to IDLE with no grant; last is kept, so the rotation continues.
//  - Read return: a MEM_LAT-deep shift register of {valid, id[1:0]} is loaded on each read grant.
//    At the pipe output, rd_rvalid[id] = valid, combinational from the pipe register.
//    rd_rdata = mem_rdata (pass-through).
//    Reads return strictly in issue order; writes do not enter the pipe.
//  - Ordering: accesses reach the RAM in grant order.
//    A read granted after a write to the same address returns the new data.
//  - A write with strb=0 is still granted: mem_we=1, mem_strb=0, so memory is unchanged.
//  - No backpressure on read return; readers must accept rd_rvalid data unconditionally.
//  - Reset (async, rstn=0):
//    - fsm=IDLE, last=3 (so rd0 wins first), cur=0, hcnt=0, pipe cleared.
//    - All grants, mem_en, mem_we and rd_rvalid are forced to 0 while rstn=0, regardless of req.
//    - Reset mid-operation drops in-flight reads; no rd_rvalid is produced for them.
//  - Requests that change before being granted are legal; only the value in the grant cycle is used.
// TESTING
//  1 Reset: rstn=0 with all req=1 -> all gnt=0, mem_en=0. First cycle after release -> rd_gnt=3'b001.
//  2 rd1 only, 10 consecutive reqs to addr 0..9, MEM_LAT=1 -> gnt every cycle, no bubbles.
//    rd_rvalid=3'b010 one cycle after each grant, with data of words 0..9 in order.
//  3 All four req held high for 64 cycles, MAX_HOLD=4 -> sequence rd0 x4, rd1 x4, rd2 x4, wr x4, repeating.
//    16 grants each; mem_en=1 every cycle.
//  4 wr word 0x10, data 0xA5 repeated, strb=16'h000F, then rd2 reads 0x10 next cycle.
//    -> rdata bytes 0..3 = 0xA5, bytes 4..15 unchanged.
//  5 MEM_LAT=2, rd0 granted, rstn pulsed low one cycle later -> no rd_rvalid within 4 cycles after release.
//  6 MAX_HOLD=1, rd0 and wr held high -> grants alternate rd0, wr, rd0, wr ...
//    Hold-exhaust check: only rd0 requesting -> granted every cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, word-addressed RAM between three read engines
// (rd0..rd2) and one write engine (wr). The arbiter is round-robin and lets
// one owner keep the port for up to MAX_HOLD consecutive beats. Read data is
// routed back to the issuing reader, in issue order, through a MEM_LAT-deep
// tag pipe.

module mem_port_arbiter #(
   parameter int AXI_WIDTH      = 128,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int MEM_LAT        = 1,
   parameter int MAX_HOLD       = 4,
   localparam int LSB           = $clog2(AXI_WIDTH) - 3,
   localparam int AW            = AXI_ADDR_WIDTH - LSB
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [2:0]             rd_req,
   input  logic [3*AW-1:0]        rd_addr,
   output logic [2:0]             rd_gnt,
   output logic [2:0]             rd_rvalid,
   output logic [AXI_WIDTH-1:0]   rd_rdata,
   input  logic                   wr_req,
   input  logic [AW-1:0]          wr_addr,
   input  logic [AXI_WIDTH-1:0]   wr_data,
   input  logic [AXI_WIDTH/8-1:0] wr_strb,
   output logic                   wr_gnt,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [AW-1:0]          mem_addr,
   output logic [AXI_WIDTH-1:0]   mem_wdata,
   output logic [AXI_WIDTH/8-1:0] mem_strb,
   input  logic [AXI_WIDTH-1:0]   mem_rdata
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t        fsm;
   logic [1:0]    cur;
   logic [1:0]    last;
   logic [HW-1:0] hcnt;

   logic [3:0]    req_all;
   logic [3:0]    gnt_vec;
   logic [1:0]    gnt_id;
   logic          gnt_any;
   logic          keep;
   logic [1:0]    base;
   logic [1:0]    cand;

   logic [MEM_LAT-1:0] pipe_valid;
   logic [1:0]         pipe_id [MEM_LAT];

   assign req_all = {wr_req, rd_req};

   // Pick this cycle's winner. The owner keeps the port while its hold budget
   // lasts; otherwise rotate from the owner (or last winner when idle) so the
   // previous winner is considered last.
   always_comb begin
      gnt_vec = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      keep    = 1'b0;
      cand    = '0;
      base    = (fsm == HOLD) ? cur : last;
      if (rstn) begin
         if (fsm == HOLD && req_all[cur] && hcnt < MAX_HOLD_C) begin
            keep    = 1'b1;
            gnt_any = 1'b1;
            gnt_id  = cur;
         end else begin
            for (int i = 1; i <= 4; i++) begin
               cand = base + 2'(i);
               if (!gnt_any && req_all[cand]) begin
                  gnt_any = 1'b1;
                  gnt_id  = cand;
               end
            end
         end
         if (gnt_any) begin
            gnt_vec[gnt_id] = 1'b1;
         end
      end
   end

   assign rd_gnt = gnt_vec[2:0];
   assign wr_gnt = gnt_vec[3];

   // Steer the granted requester onto the RAM port; everything idles at zero.
   always_comb begin
      mem_en    = gnt_any;
      mem_we    = gnt_vec[3];
      mem_addr  = '0;
      mem_wdata = '0;
      mem_strb  = '0;
      if (gnt_any) begin
         case (gnt_id)
            2'd0: mem_addr = rd_addr[0 +: AW];
            2'd1: mem_addr = rd_addr[AW +: AW];
            2'd2: mem_addr = rd_addr[2*AW +: AW];
            default: begin
               mem_addr  = wr_addr;
               mem_wdata = wr_data;
               mem_strb  = wr_strb;
            end
         endcase
      end
   end

   // Arbitration state: owner, hold counter and rotation pointer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fsm  <= IDLE;
         cur  <= 2'd0;
         last <= 2'd3;
         hcnt <= '0;
      end else if (keep) begin
         hcnt <= hcnt + HW'(1);
      end else if (gnt_any) begin
         fsm  <= HOLD;
         cur  <= gnt_id;
         last <= gnt_id;
         hcnt <= HW'(1);
      end else begin
         fsm  <= IDLE;
      end
   end

   // Carry the reader id alongside each read for MEM_LAT cycles so the data
   // coming back from the RAM can be tagged; writes never enter the pipe.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe_valid <= '0;
         for (int i = 0; i < MEM_LAT; i++) begin
            pipe_id[i] <= 2'd0;
         end
      end else begin
         pipe_valid[0] <= gnt_any & ~gnt_vec[3];
         pipe_id[0]    <= gnt_id;
         for (int i = 1; i < MEM_LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_id[i]    <= pipe_id[i-1];
         end
      end
   end

   // Decode the pipe output into the one-hot valid for the owning reader.
   always_comb begin
      rd_rvalid = '0;
      if (pipe_valid[MEM_LAT-1]) begin
         case (pipe_id[MEM_LAT-1])
            2'd0:    rd_rvalid = 3'b001;
            2'd1:    rd_rvalid = 3'b010;
            2'd2:    rd_rvalid = 3'b100;
            default: rd_rvalid = 3'b000;
         endcase
      end
   end

   assign rd_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Three instances share one set of
// request inputs: the default build (MEM_LAT=1, MAX_HOLD=4) backed by a small
// RAM model, a MEM_LAT=2 build and a MAX_HOLD=1 build.

module tb_mem_port_arbiter;

   localparam int W  = 128;
   localparam int AW = 28;

   logic          clk;
   logic          rstn;
   logic [2:0]    rd_req;
   logic [3*AW-1:0] rd_addr;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [W/8-1:0] wr_strb;
   logic [W-1:0]  zero_data;

   logic [2:0]    a_rd_gnt, a_rd_rvalid;
   logic [W-1:0]  a_rd_rdata, a_mem_wdata, a_mem_rdata;
   logic          a_wr_gnt, a_mem_en, a_mem_we;
   logic [AW-1:0] a_mem_addr;
   logic [W/8-1:0] a_mem_strb;

   logic [2:0]    l2_rd_gnt, l2_rd_rvalid;
   logic [W-1:0]  l2_rd_rdata, l2_mem_wdata;
   logic          l2_wr_gnt, l2_mem_en, l2_mem_we;
   logic [AW-1:0] l2_mem_addr;
   logic [W/8-1:0] l2_mem_strb;

   logic [2:0]    h1_rd_gnt, h1_rd_rvalid;
   logic [W-1:0]  h1_rd_rdata, h1_mem_wdata;
   logic          h1_wr_gnt, h1_mem_en, h1_mem_we;
   logic [AW-1:0] h1_mem_addr;
   logic [W/8-1:0] h1_mem_strb;

   logic [W-1:0]  ram [32];
   logic [W-1:0]  ram_q;

   int tests_run;
   int tests_failed;

   assign zero_data   = '0;
   assign a_mem_rdata = ram_q;

   mem_port_arbiter dut (
      .clk(clk), .rstn(rstn),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(a_rd_gnt),
      .rd_rvalid(a_rd_rvalid), .rd_rdata(a_rd_rdata),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_gnt(a_wr_gnt), .mem_en(a_mem_en), .mem_we(a_mem_we),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_strb(a_mem_strb),
      .mem_rdata(a_mem_rdata)
   );

   mem_port_arbiter #(.MEM_LAT(2)) dut_l2 (
      .clk(clk), .rstn(rstn),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(l2_rd_gnt),
      .rd_rvalid(l2_rd_rvalid), .rd_rdata(l2_rd_rdata),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_gnt(l2_wr_gnt), .mem_en(l2_mem_en), .mem_we(l2_mem_we),
      .mem_addr(l2_mem_addr), .mem_wdata(l2_mem_wdata), .mem_strb(l2_mem_strb),
      .mem_rdata(zero_data)
   );

   mem_port_arbiter #(.MAX_HOLD(1)) dut_h1 (
      .clk(clk), .rstn(rstn),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(h1_rd_gnt),
      .rd_rvalid(h1_rd_rvalid), .rd_rdata(h1_rd_rdata),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
      .wr_gnt(h1_wr_gnt), .mem_en(h1_mem_en), .mem_we(h1_mem_we),
      .mem_addr(h1_mem_addr), .mem_wdata(h1_mem_wdata), .mem_strb(h1_mem_strb),
      .mem_rdata(zero_data)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port RAM behind the default instance: byte-masked writes,
   // one-cycle registered reads.
   always @(posedge clk) begin : ram_model
      logic [W-1:0] tmp;
      if (a_mem_en) begin
         if (a_mem_we) begin
            tmp = ram[a_mem_addr[4:0]];
            for (int b = 0; b < W/8; b++) begin
               if (a_mem_strb[b]) tmp[8*b +: 8] = a_mem_wdata[8*b +: 8];
            end
            ram[a_mem_addr[4:0]] = tmp;
         end else begin
            ram_q <= ram[a_mem_addr[4:0]];
         end
      end
   end

   function automatic logic [W-1:0] word_of(input int i);
      return {4{32'hC0DE_0000 + 32'(i)}};
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] rq, input logic wq);
      rd_req = rq;
      wr_req = wq;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      applyStimulus(3'b000, 1'b0);
      next_cycle();
      rstn = 1'b1;
   endtask

   // Directed sequence; inputs change 1 unit after a rising edge and outputs
   // are checked 1 unit later.
   initial begin
      int cnt [4];
      int k;
      int kp;
      logic [3:0] g4;
      logic [3:0] exp4;
      logic [2:0] exp_rv;

      tests_run    = 0;
      tests_failed = 0;
      for (int i = 0; i < 32; i++) ram[i] = word_of(i);
      rstn    = 1'b0;
      rd_addr = '0;
      wr_addr = '0;
      wr_data = '0;
      wr_strb = '0;
      applyStimulus(3'b000, 1'b0);

      // Reset holds every grant low even with all requests up.
      rd_addr = {AW'(2), AW'(1), AW'(5)};
      applyStimulus(3'b111, 1'b1);
      #1;
      checkOutput("rst_rd_gnt", W'(a_rd_gnt), W'(3'b000));
      checkOutput("rst_wr_gnt", W'(a_wr_gnt), W'(1'b0));
      checkOutput("rst_mem_en", W'(a_mem_en), W'(1'b0));
      checkOutput("rst_mem_we", W'(a_mem_we), W'(1'b0));
      checkOutput("rst_rvalid", W'(a_rd_rvalid), W'(3'b000));
      @(posedge clk);
      #1;
      rstn = 1'b1;
      #1;
      checkOutput("first_gnt", W'(a_rd_gnt), W'(3'b001));
      checkOutput("first_wr_gnt", W'(a_wr_gnt), W'(1'b0));
      checkOutput("first_addr", W'(a_mem_addr), W'(5));
      next_cycle();

      // rd1 alone streams ten reads back to back.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(3'b010, 1'b0);
         rd_addr[AW +: AW] = AW'(i);
         #1;
         checkOutput("stream_gnt", W'(a_rd_gnt), W'(3'b010));
         checkOutput("stream_en", W'(a_mem_en), W'(1'b1));
         checkOutput("stream_addr", W'(a_mem_addr), W'(i));
         checkOutput("stream_rvalid", W'(a_rd_rvalid), (i == 0) ? W'(0) : W'(3'b010));
         if (i > 0) checkOutput("stream_rdata", a_rd_rdata, word_of(i - 1));
         next_cycle();
      end
      applyStimulus(3'b000, 1'b0);
      #1;
      checkOutput("stream_last_rvalid", W'(a_rd_rvalid), W'(3'b010));
      checkOutput("stream_last_rdata", a_rd_rdata, word_of(9));
      next_cycle();

      // All four requesting: four-beat bursts in rotation; write strb=0.
      do_reset();
      rd_addr = {AW'(3), AW'(2), AW'(1)};
      wr_addr = AW'(8'h1F);
      wr_data = '1;
      wr_strb = '0;
      for (int j = 0; j < 4; j++) cnt[j] = 0;
      applyStimulus(3'b111, 1'b1);
      for (int c = 0; c < 64; c++) begin
         #1;
         k    = (c / 4) % 4;
         exp4 = 4'(1 << k);
         g4   = {a_wr_gnt, a_rd_gnt};
         checkOutput("rr_gnt", W'(g4), W'(exp4));
         checkOutput("rr_en", W'(a_mem_en), W'(1'b1));
         checkOutput("rr_we", W'(a_mem_we), W'(k == 3));
         checkOutput("rr_addr", W'(a_mem_addr), (k == 3) ? W'(8'h1F) : W'(k + 1));
         if (k == 3) checkOutput("rr_strb0", W'(a_mem_strb), W'(0));
         kp     = ((c + 63) / 4) % 4;
         exp_rv = (c == 0 || kp == 3) ? 3'b000 : 3'(1 << kp);
         checkOutput("rr_rvalid", W'(a_rd_rvalid), W'(exp_rv));
         for (int j = 0; j < 4; j++) if (g4[j]) cnt[j]++;
         next_cycle();
      end
      for (int j = 0; j < 4; j++) checkOutput("rr_count", W'(cnt[j]), W'(16));
      checkOutput("rr_strb0_ram", ram[31], word_of(31));

      // Partial write then read-back of the same word by rd2.
      do_reset();
      wr_addr = AW'(8'h10);
      wr_data = {16{8'hA5}};
      wr_strb = 16'h000F;
      applyStimulus(3'b000, 1'b1);
      #1;
      checkOutput("wr_gnt", W'(a_wr_gnt), W'(1'b1));
      checkOutput("wr_rd_gnt", W'(a_rd_gnt), W'(3'b000));
      checkOutput("wr_we", W'(a_mem_we), W'(1'b1));
      checkOutput("wr_addr", W'(a_mem_addr), W'(8'h10));
      checkOutput("wr_strb", W'(a_mem_strb), W'(16'h000F));
      checkOutput("wr_wdata", a_mem_wdata, {16{8'hA5}});
      next_cycle();
      applyStimulus(3'b100, 1'b0);
      rd_addr[2*AW +: AW] = AW'(8'h10);
      #1;
      checkOutput("rbk_gnt", W'(a_rd_gnt), W'(3'b100));
      checkOutput("rbk_we", W'(a_mem_we), W'(1'b0));
      checkOutput("rbk_strb", W'(a_mem_strb), W'(0));
      checkOutput("rbk_wdata", a_mem_wdata, W'(0));
      checkOutput("rbk_addr", W'(a_mem_addr), W'(8'h10));
      next_cycle();
      applyStimulus(3'b000, 1'b0);
      #1;
      checkOutput("rbk_rvalid", W'(a_rd_rvalid), W'(3'b100));
      checkOutput("rbk_rdata", a_rd_rdata,
                  {32'hC0DE_0010, 32'hC0DE_0010, 32'hC0DE_0010, 32'hA5A5_A5A5});
      next_cycle();

      // MEM_LAT=2: data valid two cycles after grant, then reset drops it.
      do_reset();
      rd_addr[0 +: AW] = AW'(4);
      applyStimulus(3'b001, 1'b0);
      #1;
      checkOutput("l2_gnt", W'(l2_rd_gnt), W'(3'b001));
      next_cycle();
      applyStimulus(3'b000, 1'b0);
      #1;
      checkOutput("l2_rvalid_lat1", W'(l2_rd_rvalid), W'(3'b000));
      next_cycle();
      #1;
      checkOutput("l2_rvalid_lat2", W'(l2_rd_rvalid), W'(3'b001));
      next_cycle();
      #1;
      checkOutput("l2_rvalid_after", W'(l2_rd_rvalid), W'(3'b000));
      next_cycle();
      applyStimulus(3'b001, 1'b0);
      #1;
      checkOutput("l2_gnt2", W'(l2_rd_gnt), W'(3'b001));
      next_cycle();
      rstn = 1'b0;
      #1;
      checkOutput("l2_rst_gnt", W'(l2_rd_gnt), W'(3'b000));
      checkOutput("l2_rst_en", W'(l2_mem_en), W'(1'b0));
      checkOutput("l2_rst_rvalid", W'(l2_rd_rvalid), W'(3'b000));
      applyStimulus(3'b000, 1'b0);
      next_cycle();
      rstn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checkOutput("l2_dropped", W'(l2_rd_rvalid), W'(3'b000));
         next_cycle();
      end

      // MAX_HOLD=1: rd0 and wr alternate, then rd0 alone every cycle.
      do_reset();
      applyStimulus(3'b001, 1'b1);
      for (int c = 0; c < 8; c++) begin
         #1;
         checkOutput("h1_alt", W'({h1_wr_gnt, h1_rd_gnt}),
                     (c % 2 == 0) ? W'(4'b0001) : W'(4'b1000));
         next_cycle();
      end
      applyStimulus(3'b001, 1'b0);
      for (int c = 0; c < 6; c++) begin
         #1;
         checkOutput("h1_solo_gnt", W'(h1_rd_gnt), W'(3'b001));
         checkOutput("h1_solo_en", W'(h1_mem_en), W'(1'b1));
         next_cycle();
      end

      // Going idle keeps the rotation pointer: after rd0, rd1 wins next.
      do_reset();
      applyStimulus(3'b001, 1'b0);
      #1;
      checkOutput("idle_first", W'(a_rd_gnt), W'(3'b001));
      next_cycle();
      applyStimulus(3'b000, 1'b0);
      #1;
      checkOutput("idle_gnt", W'({a_wr_gnt, a_rd_gnt}), W'(4'b0000));
      checkOutput("idle_en", W'(a_mem_en), W'(1'b0));
      checkOutput("idle_addr", W'(a_mem_addr), W'(0));
      next_cycle();
      applyStimulus(3'b111, 1'b1);
      #1;
      checkOutput("idle_rotate", W'({a_wr_gnt, a_rd_gnt}), W'(4'b0010));
      next_cycle();
      applyStimulus(3'b000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
